// File: rtl/jtexterm_arb_pkg.sv
// Shared definitions for the ROM slot arbiter: FSM states and requester indices.
package jtexterm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] REQ_MAIN = 2'd0;
  localparam logic [1:0] REQ_SUB  = 2'd1;
  localparam logic [1:0] REQ_GFX  = 2'd2;

  // Next requester in round-robin order main -> sub -> gfx -> main.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == REQ_GFX) ? REQ_MAIN : idx + 2'd1;
  endfunction

endpackage

// File: rtl/jtexterm_romslot_cache.sv
// One-entry cache: tag, data and valid bit with a combinational hit flag.
module jtexterm_romslot_cache #(
  parameter int TW = 16,
  parameter int DW = 16
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic          set_valid,
  input  logic [TW-1:0] wtag,
  input  logic [DW-1:0] wdata,
  input  logic          cs,
  input  logic [TW-1:0] tag,
  output logic          ok,
  output logic [DW-1:0] data
);

  logic          valid_reg;
  logic [TW-1:0] tag_reg;
  logic [DW-1:0] data_reg;

  // Fill on write; a fill decides valid itself, otherwise clr wipes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else begin
      if (we) begin
        tag_reg   <= wtag;
        data_reg  <= wdata;
        valid_reg <= set_valid;
      end else if (clr) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Hit is purely combinational so a cached read costs no cycles.
  always_comb begin
    ok   = cs & valid_reg & (tag_reg == tag);
    data = data_reg;
  end

endmodule

// File: rtl/jtexterm_romslot_arb.sv
// Three-way ROM slot arbiter in front of an SDRAM bank: main, sub and gfx
// each get a one-entry cache; misses are served round-robin.
module jtexterm_romslot_arb
  import jtexterm_arb_pkg::*;
#(
  parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
  parameter logic [21:0] SUB_OFFSET  = 22'h01_0000,
  parameter logic [21:0] GFX_OFFSET  = 22'h02_0000
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        downloading,
  input  logic        main_cs,
  input  logic [16:0] main_addr,
  output logic [7:0]  main_data,
  output logic        main_ok,
  input  logic        sub_cs,
  input  logic [15:0] sub_addr,
  output logic [7:0]  sub_data,
  output logic        sub_ok,
  input  logic        gfx_cs,
  input  logic [19:0] gfx_addr,
  output logic [31:0] gfx_data,
  output logic        gfx_ok,
  output logic [21:0] ba_addr,
  output logic        ba_rd,
  input  logic        ba_ack,
  input  logic        ba_dok,
  input  logic        ba_rdy,
  input  logic [15:0] data_read
);

  arb_state_t  state_reg, state_next;
  logic [1:0]  gnt_reg, last_reg;
  logic [19:0] tag_lat_reg;
  logic [21:0] addr_reg;
  logic [15:0] w0_reg, w1_reg, w0_next, w1_next;
  logic        cnt_reg;
  logic        dl_seen_reg;

  logic [2:0]  pend;
  logic        found;
  logic [1:0]  gidx, cand;
  logic        fill, we_main, we_sub, we_gfx, set_valid;
  logic [15:0] main_word, sub_word;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Round-robin pick and next-state logic.
  always_comb begin
    pend  = {gfx_cs & ~gfx_ok, sub_cs & ~sub_ok, main_cs & ~main_ok};
    found = 1'b0;
    gidx  = REQ_MAIN;
    cand  = last_reg;
    for (int k = 0; k < 3; k++) begin
      cand = rr_next(cand);
      if (!found && pend[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!downloading && found) state_next = ST_REQ;
      ST_REQ:  if (ba_ack) state_next = ST_DATA;
      ST_DATA: if (ba_rdy) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: SDRAM request and cache fill strobes.
  always_comb begin
    ba_rd     = (state_reg == ST_REQ);
    ba_addr   = addr_reg;
    fill      = (state_reg == ST_DATA) && ba_rdy;
    we_main   = fill && (gnt_reg == REQ_MAIN);
    we_sub    = fill && (gnt_reg == REQ_SUB);
    we_gfx    = fill && (gnt_reg == REQ_GFX);
    set_valid = ~dl_seen_reg & ~downloading;
    // A dok coinciding with rdy must still land in the cache.
    w0_next   = (state_reg == ST_DATA && ba_dok && !cnt_reg) ? data_read : w0_reg;
    w1_next   = (state_reg == ST_DATA && ba_dok &&  cnt_reg) ? data_read : w1_reg;
  end

  // Transaction datapath: latch grant/tag/address, capture words, track downloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_reg     <= REQ_MAIN;
      last_reg    <= REQ_GFX;
      tag_lat_reg <= '0;
      addr_reg    <= '0;
      w0_reg      <= '0;
      w1_reg      <= '0;
      cnt_reg     <= 1'b0;
      dl_seen_reg <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && state_next == ST_REQ) begin
        gnt_reg     <= gidx;
        last_reg    <= gidx;
        cnt_reg     <= 1'b0;
        dl_seen_reg <= 1'b0;
        case (gidx)
          REQ_MAIN: begin
            tag_lat_reg <= {4'd0, main_addr[16:1]};
            addr_reg    <= MAIN_OFFSET + {6'd0, main_addr[16:1]};
          end
          REQ_SUB: begin
            tag_lat_reg <= {5'd0, sub_addr[15:1]};
            addr_reg    <= SUB_OFFSET + {7'd0, sub_addr[15:1]};
          end
          default: begin
            tag_lat_reg <= gfx_addr;
            addr_reg    <= GFX_OFFSET + {1'b0, gfx_addr, 1'b0};
          end
        endcase
      end else begin
        if (state_reg != ST_IDLE && downloading) dl_seen_reg <= 1'b1;
        if (state_reg == ST_DATA && ba_dok) begin
          w0_reg  <= w0_next;
          w1_reg  <= w1_next;
          cnt_reg <= ~cnt_reg;
        end
      end
    end
  end

  jtexterm_romslot_cache #(.TW(16), .DW(16)) u_main (
    .rst(rst), .clk(clk), .clr(downloading), .we(we_main), .set_valid(set_valid),
    .wtag(tag_lat_reg[15:0]), .wdata(w0_next),
    .cs(main_cs), .tag(main_addr[16:1]), .ok(main_ok), .data(main_word)
  );

  jtexterm_romslot_cache #(.TW(15), .DW(16)) u_sub (
    .rst(rst), .clk(clk), .clr(downloading), .we(we_sub), .set_valid(set_valid),
    .wtag(tag_lat_reg[14:0]), .wdata(w0_next),
    .cs(sub_cs), .tag(sub_addr[15:1]), .ok(sub_ok), .data(sub_word)
  );

  jtexterm_romslot_cache #(.TW(20), .DW(32)) u_gfx (
    .rst(rst), .clk(clk), .clr(downloading), .we(we_gfx), .set_valid(set_valid),
    .wtag(tag_lat_reg), .wdata({w1_next, w0_next}),
    .cs(gfx_cs), .tag(gfx_addr), .ok(gfx_ok), .data(gfx_data)
  );

  // Byte lane select for the 8-bit requesters.
  always_comb begin
    main_data = main_addr[0] ? main_word[15:8] : main_word[7:0];
    sub_data  = sub_addr[0]  ? sub_word[15:8]  : sub_word[7:0];
  end

endmodule

// File: tb/tb_jtexterm_romslot_arb.sv
// Directed bench for the ROM slot arbiter with a hand-driven SDRAM side.
module tb_jtexterm_romslot_arb;

  logic        rst, clk, downloading;
  logic        main_cs, sub_cs, gfx_cs;
  logic [16:0] main_addr;
  logic [15:0] sub_addr;
  logic [19:0] gfx_addr;
  logic [7:0]  main_data, sub_data;
  logic [31:0] gfx_data;
  logic        main_ok, sub_ok, gfx_ok;
  logic [21:0] ba_addr;
  logic        ba_rd, ba_ack, ba_dok, ba_rdy;
  logic [15:0] data_read;

  int errors = 0;
  int checks = 0;

  jtexterm_romslot_arb dut (
    .rst(rst), .clk(clk), .downloading(downloading),
    .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
    .sub_cs(sub_cs), .sub_addr(sub_addr), .sub_data(sub_data), .sub_ok(sub_ok),
    .gfx_cs(gfx_cs), .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_ok(gfx_ok),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dok(ba_dok),
    .ba_rdy(ba_rdy), .data_read(data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for ba_rd, ack after ack_dly cycles, then one idle cycle
  // and nwords dok beats with rdy on the last one. Returns at the negedge
  // after the rdy clock edge.
  task automatic serve(input int ack_dly, input int nwords,
                       input logic [15:0] d0, input logic [15:0] d1,
                       output logic [21:0] addr_seen, output bit timeout);
    timeout   = 1'b1;
    addr_seen = '0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ba_rd) begin
        timeout = 1'b0;
        break;
      end
    end
    if (timeout) return;
    addr_seen = ba_addr;
    repeat (ack_dly - 1) @(negedge clk);
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nwords; i++) begin
      ba_dok    = 1'b1;
      data_read = (i == 0) ? d0 : d1;
      ba_rdy    = (i == nwords - 1);
      @(negedge clk);
    end
    ba_dok = 1'b0;
    ba_rdy = 1'b0;
    data_read = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    main_cs = 1'b0; sub_cs = 1'b0; gfx_cs = 1'b0; downloading = 1'b0;
    main_addr = '0; sub_addr = '0; gfx_addr = '0;
    ba_ack = 1'b0; ba_dok = 1'b0; ba_rdy = 1'b0; data_read = '0;
    rst = 1'b1;
    #1;
    checks++; if (ba_rd !== 1'b0) begin errors++; $display("FAIL reset_ba_rd got=%b exp=0", ba_rd); end
    checks++; if (ba_addr !== 22'd0) begin errors++; $display("FAIL reset_ba_addr got=%h exp=0", ba_addr); end
    checks++; if ({main_ok, sub_ok, gfx_ok} !== 3'b000) begin errors++; $display("FAIL reset_ok got=%b exp=000", {main_ok, sub_ok, gfx_ok}); end
    checks++; if ({main_data, sub_data, gfx_data} !== 48'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {main_data, sub_data, gfx_data}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_main_miss;
    logic [21:0] a; bit to;
    main_cs = 1'b1; main_addr = 17'h00005;
    #1;
    checks++; if (main_ok !== 1'b0) begin errors++; $display("FAIL miss_ok_early got=%b exp=0", main_ok); end
    serve(2, 1, 16'hBEEF, 16'h0000, a, to);
    checks++; if (to) begin errors++; $display("FAIL miss_timeout got=timeout exp=ba_rd"); end
    checks++; if (a !== 22'h000002) begin errors++; $display("FAIL miss_addr got=%h exp=000002", a); end
    checks++; if (main_ok !== 1'b1) begin errors++; $display("FAIL miss_ok got=%b exp=1", main_ok); end
    checks++; if (main_data !== 8'hBE) begin errors++; $display("FAIL miss_data got=%h exp=be", main_data); end
    $display("test_main_miss: addr=%h data=%h ok=%b", a, main_data, main_ok);
  endtask

  task automatic test_hit;
    bit rd_seen = 1'b0;
    main_addr = 17'h00004;
    #1;
    checks++; if (main_ok !== 1'b1) begin errors++; $display("FAIL hit_ok got=%b exp=1", main_ok); end
    checks++; if (main_data !== 8'hEF) begin errors++; $display("FAIL hit_data got=%h exp=ef", main_data); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ba_rd) rd_seen = 1'b1;
    end
    checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL hit_no_rd got=%b exp=0", rd_seen); end
    main_cs = 1'b0;
    $display("test_hit: data=%h ok=%b", main_data, main_ok);
  endtask

  task automatic test_gfx_burst;
    logic [21:0] a; bit to;
    gfx_cs = 1'b1; gfx_addr = 20'h00010;
    serve(2, 2, 16'h1111, 16'h2222, a, to);
    checks++; if (to) begin errors++; $display("FAIL gfx_timeout got=timeout exp=ba_rd"); end
    checks++; if (a !== 22'h020020) begin errors++; $display("FAIL gfx_addr got=%h exp=020020", a); end
    checks++; if (gfx_ok !== 1'b1) begin errors++; $display("FAIL gfx_ok got=%b exp=1", gfx_ok); end
    checks++; if (gfx_data !== 32'h2222_1111) begin errors++; $display("FAIL gfx_data got=%h exp=22221111", gfx_data); end
    gfx_cs = 1'b0;
    $display("test_gfx_burst: addr=%h data=%h", a, gfx_data);
  endtask

  task automatic test_contention;
    logic [21:0] a; bit to;
    logic [21:0] exp_addr [3];
    exp_addr[0] = 22'h000080;
    exp_addr[1] = 22'h010100;
    exp_addr[2] = 22'h020006;
    do_reset();
    main_cs = 1'b1; main_addr = 17'h00100;
    sub_cs  = 1'b1; sub_addr  = 16'h0201;
    gfx_cs  = 1'b1; gfx_addr  = 20'h00003;
    for (int n = 0; n < 3; n++) begin
      serve(1, (n == 2) ? 2 : 1, 16'hA500 + 16'(n), 16'h5A5A, a, to);
      checks++; if (to || a !== exp_addr[n]) begin errors++; $display("FAIL contention_grant%0d got=%h exp=%h", n, a, exp_addr[n]); end
      $display("test_contention: grant %0d addr=%h", n, a);
    end
    checks++; if ({main_ok, sub_ok, gfx_ok} !== 3'b111) begin errors++; $display("FAIL contention_ok got=%b exp=111", {main_ok, sub_ok, gfx_ok}); end
    checks++; if (sub_data !== 8'hA5) begin errors++; $display("FAIL contention_sub_data got=%h exp=a5", sub_data); end
    main_cs = 1'b0; gfx_cs = 1'b0; sub_cs = 1'b0;
  endtask

  task automatic test_download;
    logic [21:0] a; bit to = 1'b1;
    sub_cs = 1'b1; sub_addr = 16'h00AA;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ba_rd) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL dl_timeout got=timeout exp=ba_rd"); end
    checks++; if (ba_addr !== 22'h010055) begin errors++; $display("FAIL dl_addr got=%h exp=010055", ba_addr); end
    ba_ack = 1'b1;
    @(negedge clk);
    ba_ack = 1'b0;
    downloading = 1'b1;
    @(negedge clk);
    downloading = 1'b0;
    ba_dok = 1'b1; ba_rdy = 1'b1; data_read = 16'h1234;
    @(negedge clk);
    ba_dok = 1'b0; ba_rdy = 1'b0; data_read = '0;
    checks++; if (sub_ok !== 1'b0) begin errors++; $display("FAIL dl_ok_low got=%b exp=0", sub_ok); end
    serve(1, 1, 16'h6789, 16'h0000, a, to);
    checks++; if (to || a !== 22'h010055) begin errors++; $display("FAIL dl_rerequest got=%h exp=010055", a); end
    checks++; if (sub_ok !== 1'b1 || sub_data !== 8'h89) begin errors++; $display("FAIL dl_refill got=%b/%h exp=1/89", sub_ok, sub_data); end
    $display("test_download: refill addr=%h data=%h", a, sub_data);
  endtask

  task automatic test_reset_mid;
    bit to = 1'b1;
    main_cs = 1'b1; main_addr = 17'h01000;
    #1;
    checks++; if (sub_ok !== 1'b1) begin errors++; $display("FAIL rmid_sub_hit got=%b exp=1", sub_ok); end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ba_rd) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL rmid_timeout got=timeout exp=ba_rd"); end
    rst = 1'b1;
    #1;
    checks++; if (ba_rd !== 1'b0) begin errors++; $display("FAIL rmid_ba_rd got=%b exp=0", ba_rd); end
    checks++; if ({main_ok, sub_ok, gfx_ok} !== 3'b000) begin errors++; $display("FAIL rmid_ok got=%b exp=000", {main_ok, sub_ok, gfx_ok}); end
    main_cs = 1'b0; sub_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("test_reset_mid: ba_rd=%b", ba_rd);
  endtask

  initial begin
    test_reset();
    test_main_miss();
    test_hit();
    test_gfx_burst();
    test_contention();
    test_download();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtexterm_romslot_arb.md
JTEXTERM_ROMSLOT_ARB -- requirements
Module: jtexterm_romslot_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MAIN_OFFSET  22'h00_0000  SDRAM word offset of main ROM.
- SUB_OFFSET   22'h01_0000  SDRAM word offset of sub ROM.
- GFX_OFFSET   22'h02_0000  SDRAM word offset of GFX ROM.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning. Clock and reset come first. The block has one clock, clk; reset rst is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- clk  in  1  SDRAM clock.
- downloading  in  1  ROM load in progress.
- main_cs  in  1  main request.
- main_addr  in  17  main byte address.
- main_data  out  8  main byte.
- main_ok  out  1  main data valid.
- sub_cs  in  1  sub request.
- sub_addr  in  16  sub byte address.
- sub_data  out  8  sub byte.
- sub_ok  out  1  sub data valid.
- gfx_cs  in  1  gfx request.
- gfx_addr  in  20  gfx 32-bit word address.
- gfx_data  out  32  gfx word.
- gfx_ok  out  1  gfx data valid.
- ba_addr  out  22  SDRAM word address.
- ba_rd  out  1  SDRAM read request.
- ba_ack  in  1  request accepted.
- ba_dok  in  1  data word present on data_read.
- ba_rdy  in  1  last word delivered.
- data_read  in  16  SDRAM data.

Function
REQ-003 Each requester SHALL own a one-entry cache holding a tag, data and a valid bit. The tag is main_addr[16:1], sub_addr[15:1] or gfx_addr.
REQ-004 ok SHALL equal cs AND valid AND (tag == current tag), combinationally.
REQ-005 A requester SHALL be pending when its cs is high and its ok is low.
REQ-006 main_data/sub_data SHALL select the cached word's low byte when addr[0]=0 and its high byte when addr[0]=1.
REQ-007 gfx_data SHALL be {second word, first word}.
REQ-008 FSM states SHALL be IDLE, REQ, DATA.
REQ-009 IDLE: with downloading low and at least one requester pending, the block SHALL grant one round-robin in the order main->sub->gfx, starting after the last granted requester. It SHALL latch the grant and tag, then go to REQ.
REQ-010 REQ: ba_rd=1 and ba_addr held stable; on ba_ack the block SHALL drop ba_rd the same cycle the ack is seen (registered) and go to DATA.
REQ-011 ba_addr SHALL be:
- main: MAIN_OFFSET + tag
- sub: SUB_OFFSET + tag
- gfx: GFX_OFFSET + {tag,1'b0}
All sums are 22-bit with wrap-around modulo 2^22.
REQ-012 DATA: each ba_dok cycle SHALL capture data_read into word counter position 0 or 1. main/sub use word 0 only.
REQ-013 On ba_rdy the block SHALL write the captured data to the granted cache, set valid unless downloading was seen high during the transaction, and return to IDLE. ok rises on the cycle after ba_rdy.
REQ-014 Cache-hit latency SHALL be 0 cycles. Miss latency SHALL be 1 cycle to ba_rd plus SDRAM latency plus 1 cycle.
REQ-015 If cs drops mid-transaction, the block SHALL still complete the transaction and fill the cache.
REQ-016 If the address changes mid-transaction, the block SHALL complete the transaction with the latched tag. The new address misses and is re-requested later.
REQ-017 downloading high SHALL clear all valid bits every cycle and block new grants. An in-flight transaction completes without setting valid.
REQ-018 Simultaneous pending requesters SHALL never both be granted. Round-robin guarantees each pending requester a grant within 3 transactions.
REQ-019 A pending request SHALL not be granted in the same cycle a transaction ends. The FSM passes through IDLE for at least one cycle.

Reset
REQ-020 rst high SHALL asynchronously force:
- FSM to IDLE;
- ba_rd=0, ba_addr=0;
- all valid bits=0 and all ok=0;
- data outputs=0;
- round-robin pointer to gfx, so main is first.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no cache update.

Structure
REQ-022 The state encoding and the requester-index constants SHALL live in shared package jtexterm_arb_pkg. Offsets remain parameters.
REQ-023 The one-entry cache SHALL be sub-module jtexterm_romslot_cache, instantiated three times with parameterised tag and data widths.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Main miss: main_cs=1, main_addr=17'h00005, ack at +2, dok/rdy at +4 with data_read=16'hBEEF. Required: ba_addr=22'h000002, main_data=8'hBE, main_ok=1 on the cycle after rdy.
- Hit: re-read main_addr=17'h00004 afterwards. Required: main_ok=1 the same cycle with data 8'hEF, and no ba_rd.
- GFX burst: gfx_addr=20'h00010, two dok with 16'h1111 then 16'h2222. Required: ba_addr=22'h020020, gfx_data=32'h2222_1111.
- Contention: main, sub and gfx all pending from reset. Required: grant order main, sub, gfx.
- Download mid-transaction: downloading pulses during DATA. Required: the transaction completes with ok staying 0, and a fresh request follows after downloading falls.
- Reset: reset asserted during REQ. Required: ba_rd=0 immediately, and all ok=0.
